seq_detector_param: RTL and testbench

Parametrised serial pattern detector for the LD-tests finite-state-machine set. It watches a 1-bit serial input and pulses a match output whenever the last N accepted samples equal a programmable N-bit pattern. Overlapping or non-overlapping detection is selectable at run time, and a saturating match counter is included. It generalises the fixed 3-bit "101" Moore detector to any length, any runtime-loadable pattern, a sample-enable input and match counting.

---
 rtl/seq_detector_param.sv | 79 +++++++
 tb/tb_seq_detector_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable N-bit pattern, overlap select,
// sample enable and a saturating match counter with a sticky saturation flag.
module seq_detector_param #(
  parameter int          N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic             en,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int FW = $clog2(N + 1);

  logic [N-1:0]  r_pat;
  logic [N-1:0]  r_hist;
  logic [FW-1:0] r_fill;
  logic          r_z;
  logic [CNT_W-1:0] r_count;
  logic          r_sat;

  logic [N-1:0]  w_hist_n;
  logic [FW-1:0] w_fill_n;
  logic          w_match;
  logic          w_count_match;

  always_comb begin
    w_hist_n      = {r_hist[N-2:0], w};
    w_fill_n      = (r_fill == FW'(N)) ? r_fill : r_fill + FW'(1);
    w_match       = (w_fill_n == FW'(N)) && (w_hist_n == r_pat);
    // A sample discarded by load can never count as a match.
    w_count_match = en && !load && w_match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat   <= PATTERN;
      r_hist  <= '0;
      r_fill  <= '0;
      r_z     <= 1'b0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (load) begin
        r_pat  <= pat_in;
        r_hist <= '0;
        r_fill <= '0;
        r_z    <= 1'b0;
      end else if (en) begin
        r_hist <= w_hist_n;
        r_z    <= w_match;
        r_fill <= (w_match && !overlap) ? '0 : w_fill_n;
      end else begin
        r_z    <= 1'b0;
      end

      if (clr_cnt) begin
        r_count <= '0;
        r_sat   <= 1'b0;
      end else if (w_count_match) begin
        if (r_count == '1) r_sat <= 1'b1;
        else               r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign z     = r_z;
  assign count = r_count;
  assign sat   = r_sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: queue-based reference model checked every cycle
// on two instances (8-bit and 2-bit counters), plus directed literal expectations.
module tb_seq_detector_param;

  localparam int N = 3;
  localparam logic [N-1:0] PAT0 = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1, w = 1'b0, en = 1'b0, overlap = 1'b0, load = 1'b0, clr_cnt = 1'b0;
  logic [N-1:0] pat_in = '0;
  logic z1, z2, sat1, sat2;
  logic [7:0] count1;
  logic [1:0] count2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.N(N), .PATTERN(PAT0), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .w(w), .en(en), .overlap(overlap), .load(load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z1), .count(count1), .sat(sat1));

  seq_detector_param #(.N(N), .PATTERN(PAT0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .w(w), .en(en), .overlap(overlap), .load(load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z2), .count(count2), .sat(sat2));

  // Reference model: accepted samples kept as a queue, oldest first.
  bit       q[$];
  bit [N-1:0] mpat = PAT0;
  bit       mz = 0;
  int       mc1 = 0, mc2 = 0;
  bit       ms1 = 0, ms2 = 0;

  always @(posedge clk) begin
    bit m;
    m = 0;
    if (rst) begin
      mpat = PAT0; q.delete(); mz = 0; mc1 = 0; mc2 = 0; ms1 = 0; ms2 = 0;
    end else begin
      if (load) begin
        mpat = pat_in; q.delete(); mz = 0;
      end else if (en) begin
        q.push_back(w);
        if (q.size() > N) void'(q.pop_front());
        if (q.size() == N) begin
          m = 1;
          for (int i = 0; i < N; i++) if (q[i] != mpat[N-1-i]) m = 0;
        end
        mz = m;
        if (m && !overlap) q.delete();
      end else begin
        mz = 0;
      end
      if (clr_cnt) begin
        mc1 = 0; ms1 = 0; mc2 = 0; ms2 = 0;
      end else if (m) begin
        if (mc1 == 255) ms1 = 1; else mc1++;
        if (mc2 == 3) ms2 = 1; else mc2++;
      end
    end
  end

  always @(negedge clk) begin
    nvec++;
    if (z1 !== mz) begin nerr++; $display("FAIL z1 t=%0t got %b exp %b", $time, z1, mz); end
    if (z2 !== mz) begin nerr++; $display("FAIL z2 t=%0t got %b exp %b", $time, z2, mz); end
    if (count1 !== 8'(mc1)) begin nerr++; $display("FAIL count1 t=%0t got %0d exp %0d", $time, count1, mc1); end
    if (count2 !== 2'(mc2)) begin nerr++; $display("FAIL count2 t=%0t got %0d exp %0d", $time, count2, mc2); end
    if (sat1 !== ms1) begin nerr++; $display("FAIL sat1 t=%0t got %b exp %b", $time, sat1, ms1); end
    if (sat2 !== ms2) begin nerr++; $display("FAIL sat2 t=%0t got %b exp %b", $time, sat2, ms2); end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %0d exp %0d", nm, $time, act, exp);
    end
  endtask

  task automatic send(input logic b, input logic ez, input string nm);
    w = b; en = 1'b1;
    tick();
    chk(nm, {31'd0, z1}, {31'd0, ez});
    en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_z", {31'd0, z1}, 0);
    chk("rst_count", {24'd0, count1}, 0);
    chk("rst_sat", {31'd0, sat1}, 0);

    // Overlapping: 1,0,1,0,1
    overlap = 1'b1;
    send(1, 0, "ov_s1"); send(0, 0, "ov_s2"); send(1, 1, "ov_s3");
    send(0, 0, "ov_s4"); send(1, 1, "ov_s5");
    chk("ov_count", {24'd0, count1}, 2);
    chk("ov_model_count", mc1, 2);

    // Non-overlapping: 1,0,1,0,1,0,1
    do_reset(); overlap = 1'b0;
    send(1, 0, "no_s1"); send(0, 0, "no_s2"); send(1, 1, "no_s3");
    send(0, 0, "no_s4"); send(1, 0, "no_s5"); send(0, 0, "no_s6");
    send(1, 1, "no_s7");
    chk("no_count", {24'd0, count1}, 2);

    // Load mid-stream; the en sample in the load cycle is discarded
    do_reset(); overlap = 1'b1;
    send(1, 0, "ld_s1"); send(0, 0, "ld_s2");
    load = 1'b1; pat_in = 3'b110; w = 1'b1; en = 1'b1;
    tick();
    chk("ld_z", {31'd0, z1}, 0);
    load = 1'b0;
    send(1, 0, "ld_n1"); send(1, 0, "ld_n2"); send(0, 1, "ld_n3");
    chk("ld_count", {24'd0, count1}, 1);

    // en gaps are transparent
    do_reset();
    send(1, 0, "gap_s1");
    en = 1'b0; w = 1'b0; tick(); chk("gap_i1", {31'd0, z1}, 0);
    w = 1'b1; tick(); chk("gap_i2", {31'd0, z1}, 0);
    send(0, 0, "gap_s2"); send(1, 1, "gap_s3");

    // Saturation on the 2-bit instance, then clear
    do_reset(); overlap = 1'b1;
    for (int i = 0; i < 10; i++) send(logic'(i % 2 == 0), logic'(i >= 2 && i % 2 == 0), "sat_s");
    chk("sat_count2", {30'd0, count2}, 3);
    chk("sat_sat2", {31'd0, sat2}, 1);
    chk("sat_count1", {24'd0, count1}, 4);
    chk("sat_sat1", {31'd0, sat1}, 0);
    chk("sat_model_ms2", {31'd0, ms2}, 1);
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    chk("clr_count2", {30'd0, count2}, 0);
    chk("clr_sat2", {31'd0, sat2}, 0);
    // clr_cnt wins over a simultaneous match, but z still pulses
    clr_cnt = 1'b1;
    send(1, 1, "clr_match_z");
    clr_cnt = 1'b0;
    chk("clr_match_count", {24'd0, count1}, 0);

    // Reset mid-stream restores PATTERN and discards history
    do_reset();
    load = 1'b1; pat_in = 3'b011; tick(); load = 1'b0;
    send(1, 0, "rs_s1"); send(0, 0, "rs_s2");
    do_reset();
    chk("rs_z", {31'd0, z1}, 0);
    chk("rs_count", {24'd0, count1}, 0);
    send(1, 0, "rs_n1"); send(0, 0, "rs_n2"); send(1, 1, "rs_n3");

    // Back-to-back matches with a periodic pattern
    load = 1'b1; pat_in = 3'b111; tick(); load = 1'b0; overlap = 1'b1;
    send(1, 0, "bb_s1"); send(1, 0, "bb_s2"); send(1, 1, "bb_s3"); send(1, 1, "bb_s4");
    chk("bb_count", {24'd0, count1}, 3);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
